// File: rtl/instruction_sequencer_pkg.sv
// Shared types for the JZJCoreF instruction sequencer: RV32I opcodes,
// SYSTEM funct3 codes, sequencer states, datapath select and trap cause enums.
package instruction_sequencer_pkg;

    typedef enum logic [6:0] {
        OPCODE_LUI      = 7'b0110111,
        OPCODE_AUIPC    = 7'b0010111,
        OPCODE_JAL      = 7'b1101111,
        OPCODE_JALR     = 7'b1100111,
        OPCODE_BRANCH   = 7'b1100011,
        OPCODE_LOAD     = 7'b0000011,
        OPCODE_STORE    = 7'b0100011,
        OPCODE_OP_IMM   = 7'b0010011,
        OPCODE_OP       = 7'b0110011,
        OPCODE_MISC_MEM = 7'b0001111,
        OPCODE_SYSTEM   = 7'b1110011
    } Opcode_t;

    typedef enum logic [2:0] {
        F3_PRIV  = 3'b000,
        F3_CSRRW = 3'b001,
        F3_CSRRS = 3'b010,
        F3_CSRRC = 3'b011
    } Funct3_t;

    typedef enum logic [2:0] {
        RESET_IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        HALT
    } SeqState_t;

    typedef enum logic [1:0] {
        RDSRC_ALU       = 2'd0,
        RDSRC_MEM       = 2'd1,
        RDSRC_PC_PLUS_4 = 2'd2,
        RDSRC_IMM_U     = 2'd3
    } RdSrc_t;

    typedef enum logic [1:0] {
        PCSRC_PC_PLUS_4     = 2'd0,
        PCSRC_BRANCH_TARGET = 2'd1,
        PCSRC_JAL_TARGET    = 2'd2,
        PCSRC_JALR_TARGET   = 2'd3
    } PcSrc_t;

    typedef enum logic [1:0] {
        TRAP_NONE        = 2'd0,
        TRAP_ILLEGAL     = 2'd1,
        TRAP_ENV         = 2'd2,
        TRAP_MEM_TIMEOUT = 2'd3
    } TrapCause_t;

    // Opcodes that proceed from DECODE to EXECUTE (SYSTEM is classified separately).
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
            OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
            OPCODE_MISC_MEM: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive cycles a memory request waits without memReady.
// expired pulses in the waiting cycle that brings the count to MEM_TIMEOUT;
// MEM_TIMEOUT = 0 disables expiry entirely.
module mem_timeout_counter #(
    parameter int unsigned MEM_TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam bit                       ENABLED = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST    = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

    logic [TIMEOUT_WIDTH-1:0] cnt;

    // Wait-cycle counter: clear has priority over count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + TIMEOUT_WIDTH'(1);
        end
    end

    assign expired = ENABLED && count && !clear && (cnt == LAST);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM for the JZJCoreF RV32I core:
// RESET_IDLE -> FETCH -> DECODE -> EXECUTE [-> MEMORY] -> FETCH, with a sticky HALT
// on illegal opcodes, ECALL/EBREAK and memory timeouts.
// Optional build macro INSTRUCTION_COUNTER_EN adds a 64-bit retiredCount output.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branchTaken,
    input  logic        memReady,
    output logic        memRequest,
    output logic        memWrite,
    output logic        memAddrSel,
    output logic        irWriteEnable,
    output logic        rdWriteEnable,
    output RdSrc_t      rdSrc,
    output logic        pcWriteEnable,
    output PcSrc_t      pcSrc,
    output logic        halted,
    output TrapCause_t  trapCause
`ifdef INSTRUCTION_COUNTER_EN
    ,
    output logic [63:0] retiredCount
`endif
);

    SeqState_t  state;
    TrapCause_t trap_q;
    logic       timeout_expired;

    mem_timeout_counter #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_mem_timeout_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (!memRequest || memReady),
        .count  (memRequest && !memReady),
        .expired(timeout_expired)
    );

    // Next-state sequencing and trap capture; HALT is left only through reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RESET_IDLE;
            trap_q <= TRAP_NONE;
        end else begin
            case (state)
                RESET_IDLE: state <= FETCH;
                FETCH: begin
                    if (memReady) begin
                        state <= DECODE;
                    end else if (timeout_expired) begin
                        state  <= HALT;
                        trap_q <= TRAP_MEM_TIMEOUT;
                    end
                end
                DECODE: begin
                    if (is_legal_opcode(opcode)) begin
                        state <= EXECUTE;
                    end else if (opcode == OPCODE_SYSTEM && funct3 == F3_PRIV) begin
                        state  <= HALT;
                        trap_q <= TRAP_ENV;
                    end else begin
                        state  <= HALT;
                        trap_q <= TRAP_ILLEGAL;
                    end
                end
                EXECUTE: begin
                    if (opcode == OPCODE_LOAD || opcode == OPCODE_STORE) begin
                        state <= MEMORY;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEMORY: begin
                    if (memReady) begin
                        state <= FETCH;
                    end else if (timeout_expired) begin
                        state  <= HALT;
                        trap_q <= TRAP_MEM_TIMEOUT;
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Datapath controls decoded from state, opcode, branchTaken and memReady.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        memRequest    = 1'b0;
        memWrite      = 1'b0;
        memAddrSel    = 1'b0;
        irWriteEnable = 1'b0;
        rdWriteEnable = 1'b0;
        rdSrc         = RDSRC_ALU;
        pcWriteEnable = 1'b0;
        pcSrc         = PCSRC_PC_PLUS_4;
        halted        = (state == HALT);
        trapCause     = trap_q;
        case (state)
            FETCH: begin
                memRequest    = 1'b1;
                irWriteEnable = memReady;
            end
            EXECUTE: begin
                case (opcode)
                    OPCODE_OP, OPCODE_OP_IMM, OPCODE_AUIPC: begin
                        rdWriteEnable = 1'b1;
                        pcWriteEnable = 1'b1;
                    end
                    OPCODE_LUI: begin
                        rdWriteEnable = 1'b1;
                        rdSrc         = RDSRC_IMM_U;
                        pcWriteEnable = 1'b1;
                    end
                    OPCODE_JAL: begin
                        rdWriteEnable = 1'b1;
                        rdSrc         = RDSRC_PC_PLUS_4;
                        pcWriteEnable = 1'b1;
                        pcSrc         = PCSRC_JAL_TARGET;
                    end
                    OPCODE_JALR: begin
                        rdWriteEnable = 1'b1;
                        rdSrc         = RDSRC_PC_PLUS_4;
                        pcWriteEnable = 1'b1;
                        pcSrc         = PCSRC_JALR_TARGET;
                    end
                    OPCODE_BRANCH: begin
                        pcWriteEnable = 1'b1;
                        if (branchTaken) pcSrc = PCSRC_BRANCH_TARGET;
                    end
                    OPCODE_MISC_MEM: pcWriteEnable = 1'b1;
                    default: ;
                endcase
            end
            MEMORY: begin
                memRequest = 1'b1;
                memAddrSel = 1'b1;
                memWrite   = (opcode == OPCODE_STORE);
                if (memReady) begin
                    pcWriteEnable = 1'b1;
                    if (opcode == OPCODE_LOAD) begin
                        rdWriteEnable = 1'b1;
                        rdSrc         = RDSRC_MEM;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef INSTRUCTION_COUNTER_EN
    // Retirement counter: one per PC update, wraps naturally at 2^64.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retiredCount <= '0;
        end else if (pcWriteEnable) begin
            retiredCount <= retiredCount + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. A driver builds each instruction's
// per-cycle expected outputs from the sequencing rules; a negedge process compares.
module tb_instruction_sequencer;

    localparam int TO = 6;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23, OPI = 7'h13;
    localparam logic [6:0] OP = 7'h33, FENCE = 7'h0F, SYSTEM = 7'h73;

    typedef struct packed {
        logic       mreq;
        logic       mwr;
        logic       masel;
        logic       irwe;
        logic       rdwe;
        logic [1:0] rdsrc;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       halt;
        logic [1:0] trap;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic rst;
    } item_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       branchTaken = 1'b0;
    logic       memReady = 1'b0;
    logic       memRequest, memWrite, memAddrSel, irWriteEnable, rdWriteEnable;
    logic       pcWriteEnable, halted;
    logic [1:0] rdSrc, pcSrc, trapCause;
`ifdef INSTRUCTION_COUNTER_EN
    logic [63:0] retiredCount;
    logic [63:0] exp_retired = '0;
`endif

    instruction_sequencer #(.MEM_TIMEOUT(TO), .TIMEOUT_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .branchTaken  (branchTaken),
        .memReady     (memReady),
        .memRequest   (memRequest),
        .memWrite     (memWrite),
        .memAddrSel   (memAddrSel),
        .irWriteEnable(irWriteEnable),
        .rdWriteEnable(rdWriteEnable),
        .rdSrc        (rdSrc),
        .pcWriteEnable(pcWriteEnable),
        .pcSrc        (pcSrc),
        .halted       (halted),
        .trapCause    (trapCause)
`ifdef INSTRUCTION_COUNTER_EN
        ,
        .retiredCount (retiredCount)
`endif
    );

    always #5 clock = ~clock;

    exp_t act;
    assign act = {memRequest, memWrite, memAddrSel, irWriteEnable, rdWriteEnable, rdSrc,
                  pcWriteEnable, pcSrc, halted, trapCause};

    int         checks = 0;
    int         errors = 0;
    int         ncyc = 0;
    item_t      q[$];
    logic       halted_m = 1'b0;
    logic [1:0] trap_m = 2'd0;
    logic [6:0] legal_ops[10] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPI, OP, FENCE};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model: expected outputs per cycle kind ----------------
    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = '0;
        e.mreq = 1'b1;
        e.irwe = rdy;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [6:0] op, input logic bt);
        exp_t e = '0;
        case (op)
            OP, OPI, AUIPC: begin e.rdwe = 1'b1; e.rdsrc = 2'd0; e.pcwe = 1'b1; end
            LUI:            begin e.rdwe = 1'b1; e.rdsrc = 2'd3; e.pcwe = 1'b1; end
            JAL:            begin e.rdwe = 1'b1; e.rdsrc = 2'd2; e.pcwe = 1'b1; e.pcsrc = 2'd2; end
            JALR:           begin e.rdwe = 1'b1; e.rdsrc = 2'd2; e.pcwe = 1'b1; e.pcsrc = 2'd3; end
            BRANCH:         begin e.pcwe = 1'b1; e.pcsrc = bt ? 2'd1 : 2'd0; end
            FENCE:          e.pcwe = 1'b1;
            default:        ;
        endcase
        return e;
    endfunction

    function automatic exp_t e_mem(input logic [6:0] op, input logic rdy);
        exp_t e = '0;
        e.mreq  = 1'b1;
        e.masel = 1'b1;
        e.mwr   = (op == STORE);
        e.pcwe  = rdy;
        if (rdy && op == LOAD) begin
            e.rdwe  = 1'b1;
            e.rdsrc = 2'd1;
        end
        return e;
    endfunction

    function automatic exp_t e_halt(input logic [1:0] trap);
        exp_t e = '0;
        e.halt = 1'b1;
        e.trap = trap;
        return e;
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPI, OP, FENCE};
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic [6:0] op, input logic [2:0] f3,
                         input logic bt, input logic rdy, input exp_t e);
        item_t it;
        @(posedge clock);
        #1;
        reset       = r;
        opcode      = op;
        funct3      = f3;
        branchTaken = bt;
        memReady    = rdy;
        it.e   = e;
        it.rst = r;
        q.push_back(it);
        ncyc++;
    endtask

    task automatic junk_cycle(input logic r, input logic rdy, input exp_t e);
        cycle(r, 7'($urandom), 3'($urandom), 1'($urandom), rdy, e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) junk_cycle(1'b1, 1'($urandom), '0);
        junk_cycle(1'b0, 1'($urandom), '0);
        halted_m = 1'b0;
        trap_m   = 2'd0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) junk_cycle(1'b0, 1'($urandom), e_halt(trap_m));
    endtask

    // One whole instruction: fw fetch wait cycles, mw memory wait cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                             input int mw, input logic bt);
        for (int i = 0; i < fw && i < TO; i++) junk_cycle(1'b0, 1'b0, e_fetch(1'b0));
        if (fw >= TO) begin
            halted_m = 1'b1;
            trap_m   = 2'd3;
            return;
        end
        junk_cycle(1'b0, 1'b1, e_fetch(1'b1));
        cycle(1'b0, op, f3, 1'($urandom), 1'($urandom), '0);
        if (op == SYSTEM) begin
            halted_m = 1'b1;
            trap_m   = (f3 == 3'd0) ? 2'd2 : 2'd1;
            return;
        end
        if (!legal(op)) begin
            halted_m = 1'b1;
            trap_m   = 2'd1;
            return;
        end
        cycle(1'b0, op, f3, bt, 1'($urandom), e_exec(op, bt));
        if (op == LOAD || op == STORE) begin
            for (int i = 0; i < mw && i < TO; i++)
                cycle(1'b0, op, f3, 1'($urandom), 1'b0, e_mem(op, 1'b0));
            if (mw >= TO) begin
                halted_m = 1'b1;
                trap_m   = 2'd3;
                return;
            end
            cycle(1'b0, op, f3, 1'($urandom), 1'b1, e_mem(op, 1'b1));
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            if (q.size() != 0) begin
                it = q.pop_front();
                check("outputs{req,wr,asel,irwe,rdwe,rdsrc,pcwe,pcsrc,halt,trap}",
                      64'(act), 64'(it.e));
`ifdef INSTRUCTION_COUNTER_EN
                if (it.rst) exp_retired = '0;
                check("retiredCount", retiredCount, exp_retired);
                if (it.e.pcwe) exp_retired = exp_retired + 64'd1;
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int r;
        int fw;
        int mw;
        logic [6:0] op;
        logic [2:0] f3;

        do_reset(3);
        check("reset_memRequest", 64'(memRequest), 64'd0);

        // OP with same-cycle fetch ready
        junk_cycle(1'b0, 1'b1, e_fetch(1'b1));
        #1;
        check("op_fetch_memRequest", 64'(memRequest), 64'd1);
        check("op_fetch_memAddrSel", 64'(memAddrSel), 64'd0);
        check("op_fetch_irWriteEnable", 64'(irWriteEnable), 64'd1);
        cycle(1'b0, OP, 3'd0, 1'b0, 1'b0, '0);
        cycle(1'b0, OP, 3'd0, 1'b0, 1'b0, e_exec(OP, 1'b0));
        #1;
        check("op_exec_rdWriteEnable", 64'(rdWriteEnable), 64'd1);
        check("op_exec_rdSrc", 64'(rdSrc), 64'd0);
        check("op_exec_pcWriteEnable", 64'(pcWriteEnable), 64'd1);

        // latency of the model itself
        n0 = ncyc;
        run_instr(OPI, 3'd0, 0, 0, 1'b0);
        check("latency_alu", 64'(ncyc - n0), 64'd3);
        n0 = ncyc;
        run_instr(LOAD, 3'd2, 0, 0, 1'b0);
        check("latency_load", 64'(ncyc - n0), 64'd4);

        // branches
        run_instr(BRANCH, 3'd0, 0, 0, 1'b1);
        #1;
        check("branch_taken_pcSrc", 64'(pcSrc), 64'd1);
        check("branch_taken_rdWriteEnable", 64'(rdWriteEnable), 64'd0);
        run_instr(BRANCH, 3'd1, 1, 0, 1'b0);
        #1;
        check("branch_not_taken_pcSrc", 64'(pcSrc), 64'd0);
        check("branch_not_taken_pcWriteEnable", 64'(pcWriteEnable), 64'd1);

        // store with 5 memory wait cycles
        run_instr(STORE, 3'd2, 0, 5, 1'b0);
        #1;
        check("store_ready_pcWriteEnable", 64'(pcWriteEnable), 64'd1);
        check("store_ready_memWrite", 64'(memWrite), 64'd1);

        run_instr(JAL, 3'd0, 0, 0, 1'b0);
        run_instr(JALR, 3'd0, 2, 0, 1'b0);
        run_instr(LUI, 3'd0, 0, 0, 1'b0);
        #1;
        check("lui_rdSrc", 64'(rdSrc), 64'd3);
        run_instr(AUIPC, 3'd0, 0, 0, 1'b0);
        run_instr(FENCE, 3'd0, 0, 0, 1'b0);

        // ready in the waiting cycle that would reach the limit: no trap
        run_instr(LOAD, 3'd0, TO - 1, TO - 1, 1'b0);
        #1;
        check("limit_ready_halted", 64'(halted), 64'd0);
        check("limit_ready_rdWriteEnable", 64'(rdWriteEnable), 64'd1);

        // ten retirements after reset
        do_reset(1);
        for (int i = 0; i < 10; i++) run_instr(OP, 3'd0, 0, 0, 1'b0);
        junk_cycle(1'b0, 1'b0, e_fetch(1'b0));
`ifdef INSTRUCTION_COUNTER_EN
        #1;
        check("retiredCount_10", retiredCount, 64'd10);
`endif

        // reset in the middle of a store: nothing retires
        do_reset(1);
        junk_cycle(1'b0, 1'b1, e_fetch(1'b1));
        cycle(1'b0, STORE, 3'd2, 1'b0, 1'b0, '0);
        cycle(1'b0, STORE, 3'd2, 1'b0, 1'b0, e_exec(STORE, 1'b0));
        cycle(1'b0, STORE, 3'd2, 1'b0, 1'b0, e_mem(STORE, 1'b0));
        cycle(1'b1, STORE, 3'd2, 1'b0, 1'b1, '0);
        #1;
        check("midreset_memRequest", 64'(memRequest), 64'd0);
        check("midreset_pcWriteEnable", 64'(pcWriteEnable), 64'd0);
        do_reset(1);

        // illegal opcode
        run_instr(7'h7F, 3'd0, 0, 0, 1'b0);
        halt_cycles(3);
        #1;
        check("illegal_halted", 64'(halted), 64'd1);
        check("illegal_trapCause", 64'(trapCause), 64'd1);
        do_reset(2);

        // ECALL/EBREAK, then SYSTEM with nonzero funct3
        run_instr(SYSTEM, 3'd0, 0, 0, 1'b0);
        halt_cycles(2);
        #1;
        check("env_trapCause", 64'(trapCause), 64'd2);
        do_reset(1);
        run_instr(SYSTEM, 3'd1, 0, 0, 1'b0);
        halt_cycles(2);
        do_reset(1);

        // fetch timeout; later memReady has no effect
        run_instr(OP, 3'd0, 100, 0, 1'b0);
        junk_cycle(1'b0, 1'b1, e_halt(trap_m));
        halt_cycles(3);
        #1;
        check("timeout_trapCause", 64'(trapCause), 64'd3);
        check("timeout_memRequest", 64'(memRequest), 64'd0);
        do_reset(1);

        // memory-phase timeout
        run_instr(STORE, 3'd0, 0, TO, 1'b0);
        halt_cycles(2);
        do_reset(1);

        // randomized instruction stream
        for (int k = 0; k < 250; k++) begin
            r  = $urandom_range(0, 39);
            f3 = 3'($urandom);
            if (r < 36) begin
                op = legal_ops[r % 10];
            end else if (r == 36) begin
                op = SYSTEM;
                f3 = 3'd0;
            end else if (r == 37) begin
                op = SYSTEM;
            end else begin
                op = 7'($urandom);
            end
            fw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
            run_instr(op, f3, fw, mw, 1'($urandom));
            if (halted_m) begin
                halt_cycles($urandom_range(1, 4));
                do_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 29) == 0) begin
                do_reset($urandom_range(1, 2));
            end
        end

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle control FSM for the JZJCoreF RV32I core. It sequences fetch, decode, execute, memory and writeback using the decoder's opcode/funct3 and the branch comparator result. It drives register-file, PC and instruction-register write enables, datapath mux selects and the memory request handshake. It detects illegal opcodes, ECALL/EBREAK and memory timeouts, and halts the core until reset.

Parameters:
MEM_TIMEOUT, 255, max cycles memRequest may stay high without memReady; 0 disables the timeout
TIMEOUT_WIDTH, 8, width of the internal timeout counter; MEM_TIMEOUT must fit

Ports:
clock  input  1  core clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces state RESET_IDLE
opcode  input  7  Opcode_t from the instruction decoder (IR contents)
funct3  input  3  Funct3_t from the decoder; used for SYSTEM classification
branchTaken  input  1  branch comparator result for the current instruction
memReady  input  1  memory completes the current request this cycle
memRequest  output  1  memory access requested
memWrite  output  1  request is a store; valid only with memRequest
memAddrSel  output  1  0 = PC (fetch), 1 = ALU result (load/store)
irWriteEnable  output  1  latch fetched word into IR
rdWriteEnable  output  1  write rd in the register file
rdSrc  output  2  RdSrc_t: ALU, MEM, PC_PLUS_4, IMM_U
pcWriteEnable  output  1  update PC; marks retirement
pcSrc  output  2  PcSrc_t: PC_PLUS_4, BRANCH_TARGET, JAL_TARGET, JALR_TARGET
halted  output  1  core halted; sticky until reset
trapCause  output  2  TrapCause_t: NONE, ILLEGAL, ENV (ECALL/EBREAK), MEM_TIMEOUT

Behaviour:
- States: RESET_IDLE, FETCH, DECODE, EXECUTE, MEMORY, HALT.
- Outputs are combinational from state, opcode, branchTaken and memReady. Every output is 0 in RESET_IDLE and whenever reset is high.
- RESET_IDLE: held during reset; moves to FETCH on the first edge after reset deasserts.
- FETCH: memRequest=1, memWrite=0, memAddrSel=0. While memReady=1: irWriteEnable=1, then go to DECODE. A same-cycle ready is accepted.
- DECODE: one cycle with no enables; the register file reads here.
  - Legal opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM): go to EXECUTE.
  - SYSTEM with funct3=0: go to HALT, trapCause=ENV.
  - Any other opcode, or SYSTEM with funct3!=0: go to HALT, trapCause=ILLEGAL.
- EXECUTE, next state FETCH unless noted:
  - OP / OP_IMM: rdWriteEnable=1, rdSrc=ALU, pcWriteEnable=1, pcSrc=PC_PLUS_4.
  - LUI: rdSrc=IMM_U. AUIPC: rdSrc=ALU.
  - JAL / JALR: rdWriteEnable=1, rdSrc=PC_PLUS_4, pcSrc=JAL_TARGET or JALR_TARGET.
  - BRANCH: pcWriteEnable=1; pcSrc=BRANCH_TARGET if branchTaken, else PC_PLUS_4; no rd write.
  - MISC_MEM (FENCE): no-op; pcWriteEnable=1, pcSrc=PC_PLUS_4.
  - LOAD / STORE: no enables; go to MEMORY.
- MEMORY: memRequest=1, memAddrSel=1, memWrite=(opcode==STORE). While memReady=1:
  - Load: rdWriteEnable=1, rdSrc=MEM.
  - Both: pcWriteEnable=1, pcSrc=PC_PLUS_4, then go to FETCH.
- Instruction latency with zero-wait memory: ALU/jump/branch 3 cycles; load/store 4 cycles.
- Timeout counter:
  - Clears on entry to FETCH or MEMORY and on every accepted memReady.
  - Increments each cycle memRequest=1 and memReady=0.
  - If it reaches MEM_TIMEOUT (MEM_TIMEOUT≠0): go to HALT, trapCause=MEM_TIMEOUT, memRequest drops the next cycle.
  - memReady in the cycle the count reaches the limit wins; no trap.
- HALT: every enable and memRequest is 0, halted=1, trapCause held. Leaves only on reset.
- memReady outside FETCH/MEMORY is ignored.
- Reset mid-access immediately (asynchronously) drops memRequest and all enables. An interrupted instruction does not retire.

Optional Feature:
INSTRUCTION_COUNTER_EN: adds an output port retiredCount [63:0], reset to 0, incremented by 1 on every edge where pcWriteEnable=1. It wraps from 2^64-1 to 0 and does not count in HALT. Without the macro the port and counter are absent, and the remaining behaviour is identical.

Decomposition:
- JZJCoreFTypes package gains the enums SeqState_t, RdSrc_t, PcSrc_t and TrapCause_t.
- The sequencer reuses the package's existing Opcode_t and Funct3_t.
- One sub-module, mem_timeout_counter (parameters MEM_TIMEOUT, TIMEOUT_WIDTH; ports clear, count, expired).

Test Plan:
- Reset high 3 cycles, release → RESET_IDLE 1 cycle, then FETCH with memRequest=1, memAddrSel=0; all other outputs 0 throughout reset.
- OP instruction, memReady=1 in the first FETCH cycle → irWriteEnable in cycle 1; EXECUTE in cycle 3 has rdWriteEnable=1, rdSrc=ALU, pcWriteEnable=1.
- BRANCH with branchTaken=1, then with branchTaken=0 → pcSrc=BRANCH_TARGET, then PC_PLUS_4; rdWriteEnable=0 both times.
- STORE, memReady delayed 5 cycles → MEMORY holds memRequest=1, memWrite=1 for 6 cycles; pcWriteEnable only in the ready cycle.
- memReady never asserted, MEM_TIMEOUT=4 → HALT after 4 waiting cycles with halted=1, trapCause=MEM_TIMEOUT; later memReady has no effect.
- Opcode 7'h7F → HALT, trapCause=ILLEGAL. Opcode 7'h73 with funct3=0 → trapCause=ENV. With INSTRUCTION_COUNTER_EN, 10 retired instructions → retiredCount=10.
